// File: rtl/debounce_pkg.sv
// Shared constants, widths and types for the debounced switch event front end.
package debounce_pkg;

    localparam int CLK_HZ       = 100_000_000;
    localparam int DEF_TICK_DIV = 100_000;   // 1 ms sample tick at CLK_HZ
    localparam int DEF_STABLE   = 20;        // samples needed to flip a level
    localparam int CH_W_MAX     = 4;         // channel index width for up to 16 channels

    // $clog2 that never returns 0, so a width derived from it is always usable.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Output controller state: IDLE means the event port is empty.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } out_state_t;

    // One queued switch event as seen by the consumer.
    typedef struct packed {
        logic [CH_W_MAX-1:0] ch;
        logic                rise;
        logic                ovr;
    } evt_rec_t;

endpackage

// File: rtl/debounce_scheduler_if.sv
// Event port between the debounce scheduler (master) and its consumer (slave).
// Handshake: an event transfers on a clock edge where evt_valid=1 and
// evt_ready=1. Once evt_valid is high, evt_ch/evt_rise/evt_ovr stay stable
// until that transfer; evt_valid does not depend on evt_ready.
interface debounce_scheduler_if
    import debounce_pkg::*;
#(
    parameter int CH = 4
) ();

    localparam int CHW = safe_clog2(CH);

    logic           evt_valid;
    logic           evt_ready;
    logic [CHW-1:0] evt_ch;
    logic           evt_rise;
    logic           evt_ovr;

    modport master (
        output evt_valid, evt_ch, evt_rise, evt_ovr,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_ch, evt_rise, evt_ovr,
        output evt_ready
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or above i_ptr, wrapping.
module rr_arbiter
    import debounce_pkg::*;
#(
    parameter  int CH  = 4,
    localparam int CHW = safe_clog2(CH)
) (
    input  logic [CH-1:0]  i_req,
    input  logic [CHW-1:0] i_ptr,
    output logic           o_any,
    output logic [CH-1:0]  o_gnt,
    output logic [CHW-1:0] o_idx
);

    localparam logic [CHW:0] CH_V = (CHW+1)'(CH);

    logic [CH-1:0] w_rot;
    logic [CHW:0]  w_sum;

    // Rotate requests so bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        w_rot = CH'({i_req, i_req} >> i_ptr);
        o_any = 1'b0;
        w_sum = '0;
        for (int k = 0; k < CH; k++) begin
            if (!o_any && w_rot[k]) begin
                o_any = 1'b1;
                w_sum = {1'b0, i_ptr} + (CHW+1)'(k);
            end
        end
        o_idx = (w_sum >= CH_V) ? CHW'(w_sum - CH_V) : CHW'(w_sum);
        o_gnt = o_any ? (CH'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/debounce_scheduler.sv
// Multi-channel switch debouncer with a shared sample tick, one pending event
// slot per channel and a round-robin serialiser onto a valid/ready port.
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int CH       = 4,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int STABLE   = DEF_STABLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CH-1:0]        sw,
    output logic [CH-1:0]        db_level,
    output out_state_t           o_fsm_state,
    debounce_scheduler_if.master evt
);

    localparam int CHW = safe_clog2(CH);
    localparam int PW  = safe_clog2(TICK_DIV);
    localparam int CW  = safe_clog2(STABLE + 1);

    localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(STABLE - 1);
    localparam logic [CHW-1:0] PTR_LAST  = CHW'(CH - 1);

    logic [CH-1:0]  r_sync1;
    logic [CH-1:0]  r_sync2;
    logic [PW-1:0]  r_presc;
    logic [CH-1:0]  r_level;
    logic [CW-1:0]  r_cnt [CH];
    logic [CH-1:0]  r_pend;
    logic [CH-1:0]  r_pdir;
    logic [CH-1:0]  r_povr;
    logic [CHW-1:0] r_ptr;
    out_state_t     r_state;
    logic [CHW-1:0] r_ch;
    logic           r_rise;
    logic           r_ovr;

    logic           w_tick;
    logic [CH-1:0]  w_post;
    logic           w_load;
    logic           w_any;
    logic [CH-1:0]  w_gnt;
    logic [CH-1:0]  w_grant;
    logic [CHW-1:0] w_idx;

    // Two-flop synchroniser for the raw switch inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    // Shared prescaler; the tick is the last count of each period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else begin
            r_presc <= (r_presc == TICK_LAST) ? '0 : r_presc + 1'b1;
        end
    end

    assign w_tick = (r_presc == TICK_LAST);

    // A channel posts an event on the tick where its run of differing samples completes.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            w_post[i] = w_tick && (r_sync2[i] != r_level[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

    // Per-channel run counters and debounced levels, advanced only on the tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
            for (int i = 0; i < CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_tick) begin
            for (int i = 0; i < CH; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_level[i] <= ~r_level[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // The output register can take a new event when empty or being accepted this cycle.
    assign w_load  = (r_state == ST_IDLE) || evt.evt_ready;
    assign w_grant = w_load ? w_gnt : '0;

    rr_arbiter #(
        .CH (CH)
    ) u_arb (
        .i_req (r_pend),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    // Pending slots: a post always wins over a same-cycle grant; overwrite flags a lost event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
            r_pdir <= '0;
            r_povr <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (w_post[i]) begin
                    r_pend[i] <= 1'b1;
                    r_pdir[i] <= r_sync2[i];
                    r_povr[i] <= r_pend[i] & ~w_grant[i];
                end else if (w_grant[i]) begin
                    r_pend[i] <= 1'b0;
                    r_povr[i] <= 1'b0;
                end
            end
        end
    end

    // Output controller: loads the granted slot into the event register and tracks fullness.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_ch    <= '0;
            r_rise  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_load && w_any) begin
                r_ch   <= w_idx;
                r_rise <= r_pdir[w_idx];
                r_ovr  <= r_povr[w_idx];
                r_ptr  <= (w_idx == PTR_LAST) ? '0 : w_idx + 1'b1;
            end
            case (r_state)
                ST_IDLE: if (w_any) r_state <= ST_FULL;
                ST_FULL: if (evt.evt_ready && !w_any) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign evt.evt_valid = (r_state == ST_FULL);
    assign evt.evt_ch    = r_ch;
    assign evt.evt_rise  = r_rise;
    assign evt.evt_ovr   = r_ovr;
    assign db_level      = r_level;
    assign o_fsm_state   = r_state;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Self-checking bench for debounce_scheduler: directed scenarios plus random
// switch activity, all compared against a sample-counting reference model.
module tb_debounce_scheduler;
    import debounce_pkg::*;

    localparam int CH       = 4;
    localparam int CHW      = 2;
    localparam int TICK_DIV = 4;
    localparam int STABLE   = 3;
    localparam int W        = $bits(evt_rec_t);

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] sw    = '0;
    logic [CH-1:0] db_level;
    out_state_t    fsm_state;

    debounce_scheduler_if #(.CH(CH)) bus ();

    debounce_scheduler #(
        .CH       (CH),
        .TICK_DIV (TICK_DIV),
        .STABLE   (STABLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw),
        .db_level    (db_level),
        .o_fsm_state (fsm_state),
        .evt         (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // ---------------- reference model ----------------
    // Sampled input seen by the debouncer lags sw by two clocks; every TICK_DIV
    // clocks one sample is taken; STABLE consecutive samples differing from the
    // level flip it and post an event; events are served from the pointer upward.
    logic [CH-1:0] m_s1, m_s2, m_level, m_pend, m_pdir, m_povr;
    int            m_run [CH];
    int            m_div;
    logic          m_valid;
    int            m_ch;
    logic          m_rise, m_ovr;
    int            m_ptr;

    logic [W-1:0]  exp_q [$];
    evt_rec_t      got_q [$];
    int            got_cyc [$];

    function automatic evt_rec_t mk(input int ch, input logic rise, input logic ovr);
        evt_rec_t e;
        e.ch   = CH_W_MAX'(ch);
        e.rise = rise;
        e.ovr  = ovr;
        return e;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0;
        m_pend = '0; m_pdir = '0; m_povr = '0;
        for (int i = 0; i < CH; i++) m_run[i] = 0;
        m_div = 0; m_valid = 1'b0; m_ch = 0; m_rise = 1'b0; m_ovr = 1'b0; m_ptr = 0;
        exp_q.delete();
    endtask

    task automatic model_advance();
        logic          tick;
        logic [CH-1:0] post;
        logic          load;
        int            gi;
        tick  = (m_div == TICK_DIV - 1);
        m_div = (m_div + 1) % TICK_DIV;
        post  = '0;
        if (tick) begin
            for (int i = 0; i < CH; i++) begin
                if (m_s2[i] == m_level[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == STABLE) begin
                        m_level[i] = m_s2[i];
                        m_run[i]   = 0;
                        post[i]    = 1'b1;
                    end
                end
            end
        end
        load = !m_valid || bus.evt_ready;
        gi   = -1;
        if (load) begin
            for (int k = 0; k < CH; k++) begin
                if (gi < 0 && m_pend[(m_ptr + k) % CH]) gi = (m_ptr + k) % CH;
            end
        end
        if (gi >= 0) begin
            m_valid    = 1'b1;
            m_ch       = gi;
            m_rise     = m_pdir[gi];
            m_ovr      = m_povr[gi];
            m_pend[gi] = 1'b0;
            m_ptr      = (gi + 1) % CH;
        end else if (load) begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < CH; i++) begin
            if (post[i]) begin
                m_povr[i] = m_pend[i];
                m_pend[i] = 1'b1;
                m_pdir[i] = m_s2[i];
            end
        end
        m_s2 = m_s1;
        m_s1 = sw;
    endtask

    function automatic logic model_posts_next(input int ch);
        return (m_div == TICK_DIV - 1) && (m_s2[ch] != m_level[ch]) && (m_run[ch] + 1 == STABLE);
    endfunction

    // ---------------- scoreboard (samples on the falling edge) ----------------
    always @(negedge clk) begin
        evt_rec_t e_dut, e_exp;
        cyc++;
        if (reset) model_reset();
        n_vec++;
        if (db_level !== m_level) begin
            n_err++;
            $display("FAIL db_level @%0d: got %b expected %b", cyc, db_level, m_level);
        end
        n_vec++;
        if (bus.evt_valid !== m_valid) begin
            n_err++;
            $display("FAIL evt_valid @%0d: got %b expected %b", cyc, bus.evt_valid, m_valid);
        end
        n_vec++;
        if (fsm_state !== (m_valid ? ST_FULL : ST_IDLE)) begin
            n_err++;
            $display("FAIL fsm_state @%0d: got %0d expected valid=%b", cyc, fsm_state, m_valid);
        end
        if (m_valid || reset) begin
            n_vec++;
            if ({bus.evt_ch, bus.evt_rise, bus.evt_ovr} !== {CHW'(m_ch), m_rise, m_ovr}) begin
                n_err++;
                $display("FAIL evt_fields @%0d: got ch=%0d rise=%b ovr=%b expected ch=%0d rise=%b ovr=%b",
                         cyc, bus.evt_ch, bus.evt_rise, bus.evt_ovr, m_ch, m_rise, m_ovr);
            end
        end
        if (!reset && m_valid && bus.evt_ready) exp_q.push_back(mk(m_ch, m_rise, m_ovr));
        if (!reset && bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
            e_dut = mk(int'(bus.evt_ch), bus.evt_rise, bus.evt_ovr);
            got_q.push_back(e_dut);
            got_cyc.push_back(cyc);
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL evt_sb @%0d: got ch=%0d rise=%b ovr=%b expected no transfer",
                         cyc, e_dut.ch, e_dut.rise, e_dut.ovr);
            end else begin
                e_exp = exp_q.pop_front();
                if (e_dut !== e_exp) begin
                    n_err++;
                    $display("FAIL evt_sb @%0d: got ch=%0d rise=%b ovr=%b expected ch=%0d rise=%b ovr=%b",
                             cyc, e_dut.ch, e_dut.rise, e_dut.ovr, e_exp.ch, e_exp.rise, e_exp.ovr);
                end
            end
        end
        if (!reset) model_advance();
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
    endtask

    task automatic clear_log();
        got_q.delete();
        got_cyc.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        n_vec++;
        if ({db_level, bus.evt_valid, bus.evt_ch, bus.evt_rise, bus.evt_ovr} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got db=%b v=%b ch=%0d r=%b o=%b expected all 0",
                     db_level, bus.evt_valid, bus.evt_ch, bus.evt_rise, bus.evt_ovr);
        end
        n_vec++;
        if (fsm_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d expected IDLE", fsm_state);
        end
        step(3);
        reset = 1'b0;
    endtask

    task automatic test_press();
        clear_log();
        sw = 4'b0100;
        step(30);
        n_vec++;
        if (db_level[2] !== 1'b1) begin
            n_err++; $display("FAIL press_level: got %b expected 1", db_level[2]);
        end
        n_vec++;
        if (got_q.size() != 1 || got_q[0] !== mk(2, 1'b1, 1'b0)) begin
            n_err++; $display("FAIL press_event: got %0d events first=%h expected 1 event %h",
                              got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, mk(2, 1'b1, 1'b0));
        end
        sw = 4'b0000;
        step(30);
        n_vec++;
        if (got_q.size() != 2 || got_q[1] !== mk(2, 1'b0, 1'b0)) begin
            n_err++; $display("FAIL release_event: got %0d events expected 2 ending with %h",
                              got_q.size(), mk(2, 1'b0, 1'b0));
        end
    endtask

    task automatic test_glitch();
        clear_log();
        sw = 4'b0010;
        step(TICK_DIV);          // exactly one sample sees the high level
        sw = 4'b0000;
        step(30);
        sw = 4'b0010;
        step(2 * TICK_DIV);      // two samples: flips only if the run was not cleared
        sw = 4'b0000;
        step(30);
        n_vec++;
        if (db_level !== 4'b0000) begin
            n_err++; $display("FAIL glitch_level: got %b expected 0000", db_level);
        end
        n_vec++;
        if (got_q.size() != 0) begin
            n_err++; $display("FAIL glitch_events: got %0d events expected 0", got_q.size());
        end
    endtask

    task automatic test_fairness();
        evt_rec_t r1 [4];
        evt_rec_t r2 [4];
        r1[0] = mk(0, 1'b1, 1'b0); r1[1] = mk(1, 1'b1, 1'b0);
        r1[2] = mk(2, 1'b1, 1'b0); r1[3] = mk(3, 1'b1, 1'b0);
        r2[0] = mk(2, 1'b0, 1'b0); r2[1] = mk(3, 1'b0, 1'b0);
        r2[2] = mk(0, 1'b0, 1'b0); r2[3] = mk(1, 1'b1, 1'b0);
        sw = '0;
        apply_reset();
        clear_log();
        sw = 4'b1111;
        step(30);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (got_q.size() <= k || got_q[k] !== r1[k] || got_cyc[k] != got_cyc[0] + k) begin
                n_err++; $display("FAIL fair_round1[%0d]: got %0d events expected %h at slot %0d back-to-back",
                                  k, got_q.size(), r1[k], k);
            end
        end
        sw = 4'b1101;            // single event on ch1 leaves the pointer at 2
        step(30);
        sw = 4'b0010;            // every channel toggles on the same cycle
        step(30);
        n_vec++;
        if (got_q.size() != 9 || got_q[4] !== mk(1, 1'b0, 1'b0)) begin
            n_err++; $display("FAIL fair_setup: got %0d events expected 9", got_q.size());
        end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (got_q.size() <= 5 + k || got_q[5 + k] !== r2[k] || got_cyc[5 + k] != got_cyc[5] + k) begin
                n_err++; $display("FAIL fair_round2[%0d]: got %0d events expected %h back-to-back",
                                  k, got_q.size(), r2[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        sw = '0;
        apply_reset();
        clear_log();
        bus.evt_ready = 1'b0;
        sw = 4'b0001;
        step(24);
        sw = 4'b0000;
        step(24);
        n_vec++;
        if ({bus.evt_valid, bus.evt_ch, bus.evt_rise, bus.evt_ovr} !== {1'b1, 2'd0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL bp_hold: got v=%b ch=%0d r=%b o=%b expected v=1 ch=0 r=1 o=0",
                              bus.evt_valid, bus.evt_ch, bus.evt_rise, bus.evt_ovr);
        end
        bus.evt_ready = 1'b1;
        step(4);
        n_vec++;
        if (got_q.size() != 2 || got_q[0] !== mk(0, 1'b1, 1'b0) || got_q[1] !== mk(0, 1'b0, 1'b0)) begin
            n_err++; $display("FAIL bp_after_grant: got %0d events expected press then release, ovr=0",
                              got_q.size());
        end
        bus.evt_ready = 1'b0;
        sw = 4'b1000;
        step(24);
        sw = 4'b1001;
        step(24);
        sw = 4'b1000;
        step(24);
        n_vec++;
        if (bus.evt_ch !== 2'd3 || bus.evt_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_hold2: got v=%b ch=%0d expected v=1 ch=3", bus.evt_valid, bus.evt_ch);
        end
        bus.evt_ready = 1'b1;
        step(4);
        n_vec++;
        if (got_q.size() != 4 || got_q[2] !== mk(3, 1'b1, 1'b0) || got_q[3] !== mk(0, 1'b0, 1'b1)) begin
            n_err++; $display("FAIL bp_overwrite: got %0d events expected ch3 press then ch0 release ovr=1",
                              got_q.size());
        end
    endtask

    task automatic test_collision();
        logic found;
        sw = '0;
        apply_reset();
        clear_log();
        bus.evt_ready = 1'b0;
        sw = 4'b0100;
        step(24);
        sw = 4'b1100;
        step(24);
        sw = 4'b0100;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (model_posts_next(3)) begin
                bus.evt_ready = 1'b1;
                found = 1'b1;
            end
            step(1);
        end
        step(4);
        n_vec++;
        if (!found) begin
            n_err++; $display("FAIL collision_timeout: got no ch3 post within 60 cycles expected one");
        end
        n_vec++;
        if (got_q.size() != 3 || got_q[0] !== mk(2, 1'b1, 1'b0) || got_q[1] !== mk(3, 1'b1, 1'b0) ||
            got_q[2] !== mk(3, 1'b0, 1'b0) || got_cyc[2] != got_cyc[1] + 1) begin
            n_err++; $display("FAIL collision_order: got %0d events expected ch2 r1, ch3 r1, ch3 r0 ovr=0 next cycle",
                              got_q.size());
        end
    endtask

    task automatic test_reset_mid();
        sw = '0;
        apply_reset();
        bus.evt_ready = 1'b0;
        sw = 4'b1111;
        step(24);
        n_vec++;
        if (bus.evt_valid !== 1'b1) begin
            n_err++; $display("FAIL rstmid_pre: got evt_valid=%b expected 1", bus.evt_valid);
        end
        #3;
        reset = 1'b1;
        sw = 4'b0001;
        #1;
        n_vec++;
        if ({db_level, bus.evt_valid, bus.evt_ch, bus.evt_rise, bus.evt_ovr} !== '0 || fsm_state !== ST_IDLE) begin
            n_err++; $display("FAIL rstmid_clear: got db=%b v=%b ch=%0d r=%b o=%b expected all 0",
                              db_level, bus.evt_valid, bus.evt_ch, bus.evt_rise, bus.evt_ovr);
        end
        step(3);
        reset = 1'b0;
        bus.evt_ready = 1'b1;
        clear_log();
        step(11);
        n_vec++;
        if (db_level !== 4'b0000 || bus.evt_valid !== 1'b0) begin
            n_err++; $display("FAIL rstmid_early: got db=%b v=%b expected 0000/0", db_level, bus.evt_valid);
        end
        step(1);
        n_vec++;
        if (db_level !== 4'b0001) begin
            n_err++; $display("FAIL rstmid_first_tick: got db=%b expected 0001", db_level);
        end
        step(4);
        n_vec++;
        if (got_q.size() != 1 || got_q[0] !== mk(0, 1'b1, 1'b0)) begin
            n_err++; $display("FAIL rstmid_stale: got %0d events expected only ch0 press", got_q.size());
        end
    endtask

    task automatic test_random();
        sw = '0;
        apply_reset();
        for (int c = 0; c < 2600; c++) begin
            if ($urandom_range(0, 29) == 0) sw = sw ^ (CH'(1) << $urandom_range(0, CH - 1));
            if (c < 1300) bus.evt_ready = ($urandom_range(0, 3) != 0);
            else          bus.evt_ready = ($urandom_range(0, 7) == 0);
            step(1);
        end
        bus.evt_ready = 1'b1;
        step(40);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL random_drain: got %0d undelivered expected events, expected 0", exp_q.size());
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        bus.evt_ready = 1'b1;
        model_reset();
        test_reset();
        test_press();
        test_glitch();
        test_fairness();
        test_backpressure();
        test_collision();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
